// File: rtl/add_sub_sequencer_4bit_if.sv
// Signal bundle between the operand sequencer, its operand source/result sink and the 4-bit adder.
// The slave modport is the sequencer's view; the master modport is everything around it.
interface add_sub_sequencer_4bit_if;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_op;
   logic       in_ready;
   logic [3:0] a_out;
   logic [3:0] b_out;
   logic       sel_out;
   logic [3:0] s_in;
   logic       cout_in;
   logic       res_valid;
   logic [3:0] res_data;
   logic       res_cout;
   logic       res_ovf;
   logic       res_ready;

   modport slave (
      input  in_valid, in_data, in_op, s_in, cout_in, res_ready,
      output in_ready, a_out, b_out, sel_out, res_valid, res_data, res_cout, res_ovf
   );

   modport master (
      output in_valid, in_data, in_op, s_in, cout_in, res_ready,
      input  in_ready, a_out, b_out, sel_out, res_valid, res_data, res_cout, res_ovf
   );
endinterface

// File: rtl/add_sub_sequencer_4bit.sv
// Operand sequencer and result capture around a 4-bit adder/subtractor: collects A then B+op,
// holds the adder inputs for HOLD_CYCLES, then captures S/cout plus a signed-overflow flag.
//
// state   | meaning
// IDLE    | waiting for the A word
// GET_B   | A held, waiting for the B word and op
// EXEC    | adder inputs held while the hold counter runs
// RESULT  | captured result offered until res_ready
module add_sub_sequencer_4bit #(
   parameter int HOLD_CYCLES = 1
) (
   input logic                    clk,
   input logic                    rst,
   add_sub_sequencer_4bit_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GET_B  = 2'd1,
      ST_EXEC   = 2'd2,
      ST_RESULT = 2'd3
   } state_t;

   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] a_q, b_q;
   logic       sel_q;
   logic [3:0] res_data_q;
   logic       res_cout_q;
   logic       res_ovf_q;

   logic       load_a;
   logic       load_b;
   logic       capture;
   logic       ovf_calc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         a_q        <= 4'd0;
         b_q        <= 4'd0;
         sel_q      <= 1'b0;
         res_data_q <= 4'd0;
         res_cout_q <= 1'b0;
         res_ovf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load_a) begin
            a_q <= bus.in_data;
         end
         if (load_b) begin
            b_q   <= bus.in_data;
            sel_q <= bus.in_op;
         end
         if (capture) begin
            res_data_q <= bus.s_in;
            res_cout_q <= bus.cout_in;
            res_ovf_q  <= ovf_calc;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load_a  = 1'b0;
      load_b  = 1'b0;
      capture = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               load_a  = 1'b1;
               state_d = ST_GET_B;
            end
         end
         ST_GET_B: begin
            if (bus.in_valid) begin
               load_b  = 1'b1;
               cnt_d   = 4'd0;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (cnt_q == HOLD_LAST) begin
               capture = 1'b1;
               cnt_d   = 4'd0;
               state_d = ST_RESULT;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RESULT: begin
            if (bus.res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Subtract flips B's sign for the overflow test: overflow when effective operand signs agree but S differs from A.
   always_comb begin
      if (sel_q) begin
         ovf_calc = (a_q[3] != b_q[3]) && (bus.s_in[3] != a_q[3]);
      end else begin
         ovf_calc = (a_q[3] == b_q[3]) && (bus.s_in[3] != a_q[3]);
      end
   end

   assign bus.in_ready  = ((state_q == ST_IDLE) || (state_q == ST_GET_B)) && !rst;
   assign bus.res_valid = (state_q == ST_RESULT);
   assign bus.a_out     = a_q;
   assign bus.b_out     = b_q;
   assign bus.sel_out   = sel_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_cout  = res_cout_q;
   assign bus.res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_add_sub_sequencer_4bit.sv
// Directed bench: a vector table of add/subtract operations plus hand-written backpressure,
// gap, reset and long-hold sequences, each DUT wired to a behavioural 4-bit adder/subtractor.
module tb_add_sub_sequencer_4bit;

   logic clk;
   logic rst1, rst3;
   int   total, bad;

   add_sub_sequencer_4bit_if if1 ();
   add_sub_sequencer_4bit_if if3 ();

   add_sub_sequencer_4bit #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));
   add_sub_sequencer_4bit #(.HOLD_CYCLES(3)) dut3 (.clk(clk), .rst(rst3), .bus(if3.slave));

   // Behavioural adder/subtractor: subtract is A + ~B + 1, cout = 1 means no borrow.
   logic [4:0] sum1, sum3;
   assign sum1       = {1'b0, if1.a_out} + {1'b0, if1.b_out ^ {4{if1.sel_out}}} + {4'd0, if1.sel_out};
   assign if1.s_in    = sum1[3:0];
   assign if1.cout_in = sum1[4];
   assign sum3       = {1'b0, if3.a_out} + {1'b0, if3.b_out ^ {4{if3.sel_out}}} + {4'd0, if3.sel_out};
   assign if3.s_in    = sum3[3:0];
   assign if3.cout_in = sum3[4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       op;
      logic [3:0] exp_s;
      logic       exp_cout;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Drives A then B on dut1 (HOLD=1); returns at the negedge after res_valid should have risen.
   task automatic send_op1(input logic [3:0] a, input logic [3:0] b, input logic op);
      @(negedge clk);
      chk("in_ready_idle", 4'(if1.in_ready), 4'd1);
      if1.in_valid = 1'b1;
      if1.in_data  = a;
      if1.in_op    = ~op;
      @(negedge clk);
      chk("a_out_loaded", if1.a_out, a);
      chk("res_valid_getb", 4'(if1.res_valid), 4'd0);
      if1.in_data = b;
      if1.in_op   = op;
      @(negedge clk);
      if1.in_valid = 1'b0;
      chk("res_valid_exec", 4'(if1.res_valid), 4'd0);
      chk("in_ready_exec", 4'(if1.in_ready), 4'd0);
      @(negedge clk);
      chk("res_valid_latency", 4'(if1.res_valid), 4'd1);
   endtask

   task automatic ack1();
      if1.res_ready = 1'b1;
      @(negedge clk);
      if1.res_ready = 1'b0;
      chk("res_valid_after_ack", 4'(if1.res_valid), 4'd0);
      chk("in_ready_after_ack", 4'(if1.in_ready), 4'd1);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      vecs[0] = '{a:4'b0100, b:4'b0100, op:1'b0, exp_s:4'b1000, exp_cout:1'b0, exp_ovf:1'b1};
      vecs[1] = '{a:4'b0100, b:4'b1101, op:1'b0, exp_s:4'b0001, exp_cout:1'b1, exp_ovf:1'b0};
      vecs[2] = '{a:4'b1101, b:4'b1100, op:1'b1, exp_s:4'b0001, exp_cout:1'b1, exp_ovf:1'b0};
      vecs[3] = '{a:4'b0100, b:4'b0100, op:1'b1, exp_s:4'b0000, exp_cout:1'b1, exp_ovf:1'b0};
      vecs[4] = '{a:4'b1111, b:4'b0001, op:1'b0, exp_s:4'b0000, exp_cout:1'b1, exp_ovf:1'b0};
      vecs[5] = '{a:4'b0111, b:4'b1000, op:1'b1, exp_s:4'b1111, exp_cout:1'b0, exp_ovf:1'b1};
      vecs[6] = '{a:4'b1000, b:4'b1000, op:1'b0, exp_s:4'b0000, exp_cout:1'b1, exp_ovf:1'b1};

      rst1 = 1'b1;
      rst3 = 1'b1;
      if1.in_valid = 1'b0; if1.in_data = 4'd0; if1.in_op = 1'b0; if1.res_ready = 1'b0;
      if3.in_valid = 1'b0; if3.in_data = 4'd0; if3.in_op = 1'b0; if3.res_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", 4'(if1.in_ready), 4'd0);
      chk("rst_res_valid", 4'(if1.res_valid), 4'd0);
      chk("rst_a_out", if1.a_out, 4'd0);
      chk("rst_b_out", if1.b_out, 4'd0);
      chk("rst_res_data", if1.res_data, 4'd0);
      rst1 = 1'b0;
      rst3 = 1'b0;

      for (int i = 0; i < 7; i++) begin
         send_op1(vecs[i].a, vecs[i].b, vecs[i].op);
         chk($sformatf("v%0d_res_data", i), if1.res_data, vecs[i].exp_s);
         chk($sformatf("v%0d_res_cout", i), 4'(if1.res_cout), 4'(vecs[i].exp_cout));
         chk($sformatf("v%0d_res_ovf", i), 4'(if1.res_ovf), 4'(vecs[i].exp_ovf));
         chk($sformatf("v%0d_b_out", i), if1.b_out, vecs[i].b);
         chk($sformatf("v%0d_sel_out", i), 4'(if1.sel_out), 4'(vecs[i].op));
         ack1();
         chk($sformatf("v%0d_res_data_kept", i), if1.res_data, vecs[i].exp_s);
      end

      // Backpressure: result held, stray 1111 words ignored.
      send_op1(4'b0011, 4'b0010, 1'b0);
      if1.in_valid = 1'b1;
      if1.in_data  = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_res_valid", 4'(if1.res_valid), 4'd1);
         chk("bp_res_data", if1.res_data, 4'b0101);
         chk("bp_in_ready", 4'(if1.in_ready), 4'd0);
         chk("bp_a_out", if1.a_out, 4'b0011);
      end
      if1.in_valid = 1'b0;
      ack1();
      send_op1(4'b0001, 4'b0001, 1'b0);
      chk("bp_next_res", if1.res_data, 4'b0010);
      ack1();

      // Gap between A and B.
      @(negedge clk);
      if1.in_valid = 1'b1;
      if1.in_data  = 4'b1000;
      @(negedge clk);
      if1.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("gap_in_ready", 4'(if1.in_ready), 4'd1);
         chk("gap_res_valid", 4'(if1.res_valid), 4'd0);
      end
      if1.in_valid = 1'b1;
      if1.in_data  = 4'b0001;
      if1.in_op    = 1'b1;
      @(negedge clk);
      if1.in_valid = 1'b0;
      @(negedge clk);
      chk("gap_res_valid_rise", 4'(if1.res_valid), 4'd1);
      chk("gap_res_data", if1.res_data, 4'b0111);
      chk("gap_res_cout", 4'(if1.res_cout), 4'd1);
      chk("gap_res_ovf", 4'(if1.res_ovf), 4'd1);
      ack1();

      // Reset while in EXEC.
      if1.in_valid = 1'b1;
      if1.in_data  = 4'b0110;
      @(negedge clk);
      if1.in_data = 4'b0011;
      if1.in_op   = 1'b1;
      @(negedge clk);
      if1.in_valid = 1'b0;
      rst1 = 1'b1;
      chk("rst_exec_in_ready", 4'(if1.in_ready), 4'd0);
      @(negedge clk);
      chk("rst_exec_res_valid", 4'(if1.res_valid), 4'd0);
      chk("rst_exec_a_out", if1.a_out, 4'd0);
      chk("rst_exec_b_out", if1.b_out, 4'd0);
      chk("rst_exec_sel_out", 4'(if1.sel_out), 4'd0);
      chk("rst_exec_res_data", if1.res_data, 4'd0);
      chk("rst_exec_res_ovf", 4'(if1.res_ovf), 4'd0);
      rst1 = 1'b0;
      @(negedge clk);
      chk("rst_exec_in_ready_after", 4'(if1.in_ready), 4'd1);

      // Reset while in RESULT, with a competing input word.
      send_op1(4'b0011, 4'b0011, 1'b0);
      chk("pre_rst_res_data", if1.res_data, 4'b0110);
      rst1 = 1'b1;
      if1.in_valid = 1'b1;
      if1.in_data  = 4'b1010;
      @(negedge clk);
      if1.in_valid = 1'b0;
      chk("rst_res_res_valid", 4'(if1.res_valid), 4'd0);
      chk("rst_res_res_data", if1.res_data, 4'd0);
      chk("rst_res_a_out", if1.a_out, 4'd0);
      chk("rst_res_in_ready", 4'(if1.in_ready), 4'd0);
      rst1 = 1'b0;
      send_op1(4'b0010, 4'b0011, 1'b1);
      chk("post_rst_res_data", if1.res_data, 4'b1111);
      chk("post_rst_res_cout", 4'(if1.res_cout), 4'd0);
      chk("post_rst_res_ovf", 4'(if1.res_ovf), 4'd0);
      ack1();

      // HOLD_CYCLES=3: 0111 + 0001.
      @(negedge clk);
      if3.in_valid = 1'b1;
      if3.in_data  = 4'b0111;
      @(negedge clk);
      if3.in_data = 4'b0001;
      if3.in_op   = 1'b0;
      @(negedge clk);
      if3.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("h3_res_valid_low", 4'(if3.res_valid), 4'd0);
         chk("h3_in_ready", 4'(if3.in_ready), 4'd0);
         chk("h3_a_out", if3.a_out, 4'b0111);
         chk("h3_b_out", if3.b_out, 4'b0001);
         @(negedge clk);
      end
      chk("h3_res_valid", 4'(if3.res_valid), 4'd1);
      chk("h3_res_data", if3.res_data, 4'b1000);
      chk("h3_res_cout", 4'(if3.res_cout), 4'd0);
      chk("h3_res_ovf", 4'(if3.res_ovf), 4'd1);
      if3.res_ready = 1'b1;
      @(negedge clk);
      if3.res_ready = 1'b0;
      chk("h3_res_valid_ack", 4'(if3.res_valid), 4'd0);
      chk("h3_in_ready_ack", 4'(if3.in_ready), 4'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/add_sub_sequencer_4bit.md
# add_sub_sequencer_4bit

Operand sequencer and result capture stage wrapped around `adder_subtractor_4bit`. It accepts operands one word at a time over a single 4-bit valid/ready input channel: first A, then B with the operation select. It drives the adder's A/B/sel inputs from registers and holds them for a programmable settle time. It then captures S and cout, adds a signed-overflow flag, and presents the result on a valid/ready output channel.

## Interface
- `HOLD_CYCLES`, default 1: cycles A/B/sel are held in EXEC before S/cout are sampled; legal range 1..15.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: `in_data` (and `in_op` during the B word) valid.
- `in_data` in 4: operand word; first accepted word is A, second is B.
- `in_op` in 1: 0 = add, 1 = subtract; sampled only with the B word.
- `in_ready` out 1: sequencer can accept an operand word this cycle.
- `a_out` out 4: to adder A.
- `b_out` out 4: to adder B.
- `sel_out` out 1: to adder sel.
- `s_in` in 4: adder S.
- `cout_in` in 1: adder cout.
- `res_valid` out 1: result registers hold a valid result.
- `res_data` out 4: captured S.
- `res_cout` out 1: captured cout (for subtract, 1 = no borrow, A >= B unsigned).
- `res_ovf` out 1: two's-complement overflow of the operation.
- `res_ready` in 1: consumer accepts result.

## Operation
States: IDLE, GET_B, EXEC, RESULT; 2-bit encoding, reset state IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: `a_out`<=`in_data`, go to GET_B.
- GET_B:
  - `in_ready`=1.
  - On `in_valid`: `b_out`<=`in_data`, `sel_out`<=`in_op`, hold counter<=0, go to EXEC.
- EXEC:
  - `in_ready`=0; counter increments each cycle.
  - When counter == `HOLD_CYCLES`-1: `res_data`<=`s_in`, `res_cout`<=`cout_in`, `res_ovf`<=computed flag, go to RESULT.
- RESULT:
  - `res_valid`=1, `in_ready`=0.
  - On `res_ready`: go to IDLE.

Overflow, using `a_out`, `b_out` and `s_in`:
- Add: (A[3]==B[3]) && (S[3]!=A[3]).
- Subtract: (A[3]!=B[3]) && (S[3]!=A[3]).

General rules:
- The block does no arithmetic on data; S/cout pass through unchanged from the adder.
- `a_out`/`b_out`/`sel_out` keep their last loaded value outside EXEC; they are cleared only by reset.
- `res_data`/`res_cout`/`res_ovf` keep their last captured value after the handshake and are updated only by the next capture.
- `in_valid` in EXEC or RESULT is ignored; no word is consumed.
- `in_op` with the A word is ignored.

## Timing
- All outputs registered, except `in_ready` and `res_valid`, which decode directly from state.
- Reset values:
  - state IDLE, counter 0.
  - `a_out`=0, `b_out`=0, `sel_out`=0.
  - `res_data`=0, `res_cout`=0, `res_ovf`=0, `res_valid`=0.
  - `in_ready` is forced to 0 while `rst`=1.
- Handshake: a transfer occurs on an edge where valid && ready are both 1.
- Latency:
  - A accepted at edge k.
  - B accepted at the earliest at edge k+1.
  - `res_valid` rises HOLD_CYCLES edges after the B edge.
  - Throughput minimum is 3+HOLD_CYCLES cycles per operation, with `res_ready` held high.
- Back-to-back: `res_ready` acceptance edge returns to IDLE; the next A can be accepted at the following edge.
- Gaps: `in_valid` low in IDLE/GET_B holds state indefinitely; an A word may wait any time for B.
- Reset mid-operation (any state):
  - Next edge is IDLE with all outputs at reset values.
  - A partial operand pair or pending result is discarded.
- `rst` and `in_valid` together: reset wins; no word is consumed.
- Counter wrap: the counter never exceeds `HOLD_CYCLES`-1; it is cleared on entry to EXEC.

## Test plan
- Add 0100 + 0100, `in_op`=0, HOLD_CYCLES=1, `res_ready`=1 -> `res_data`=1000, `res_cout`=0, `res_ovf`=1; `res_valid` asserted 1 edge after the B edge.
- Add 0100 + 1101 -> `res_data`=0001, `res_cout`=1, `res_ovf`=0. Subtract 1101 - 1100 (`in_op`=1) -> 0001, `res_cout`=1, `res_ovf`=0. Subtract 0100 - 0100 -> 0000, `res_cout`=1, `res_ovf`=0. The bench attaches a behavioural `adder_subtractor_4bit`.
- Backpressure: hold `res_ready`=0 for 5 cycles after a result -> `res_valid`, `res_data` stable; `in_ready`=0; `in_valid` pulses with 1111 not consumed (next A after release is the bench's next word).
- HOLD_CYCLES=3, add 0111 + 0001 -> `a_out`/`b_out` stable for 3 EXEC cycles; `res_valid` 3 edges after the B edge; `res_data`=1000, `res_ovf`=1.
- Reset in EXEC and again in RESULT -> next edge: IDLE, `res_valid`=0, all outputs 0, `in_ready`=1 one cycle after `rst` falls; a fresh 0010 - 0011 then gives 1111, `res_cout`=0, `res_ovf`=0.
- Gap: A=1000 accepted, `in_valid` low 4 cycles, B=0001 `in_op`=1 -> `res_data`=0111, `res_cout`=1, `res_ovf`=1.
